heap_pq: RTL
============

# heap_pq

Parametrised on-chip binary-heap priority queue carrying key/value pairs, with a selectable min/max ordering and push, pop and replace-top commands. It sits between a producer/consumer pair in the application fabric and keeps every heap level in a local synchronous RAM, with the root cached in a register. Each accepted command produces exactly one response, so commands and responses can be counted one-for-one.

## Interface
Parameters:
- W_KEY, 32: key width; ordering uses the key only.
- W_VAL, 32: payload width; carried unmodified with its key.
- W_A, 6: RAM address width; capacity CAP = 2^W_A − 1 entries (RAM index 0 unused).
- MODE_MIN, 1: 1 = min-heap (root has the smallest key), 0 = max-heap.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0 = PUSH, 1 = POP, 2 = REPLACE (pop root, then insert), 3 = reserved (treated as error).
- cmd_key  in  W_KEY  key for PUSH/REPLACE.
- cmd_val  in  W_VAL  value for PUSH/REPLACE.
- rsp_valid  out  1  one-cycle pulse, exactly one per accepted command.
- rsp_err  out  1  qualifies rsp_valid.
- rsp_key  out  W_KEY  response key.
- rsp_val  out  W_VAL  response value.
- count  out  W_A  current number of entries.
- empty  out  1  count == 0.
- full  out  1  count == CAP.

## Operation
- better(a,b): for MODE_MIN=1, a.key <= b.key; for MODE_MIN=0, a.key >= b.key. On ties, the item already in place stays put.
- A command is accepted on a cycle where cmd_valid && cmd_ready.
- PUSH:
  - When full: rsp_err=1, heap unchanged.
  - Otherwise: count++, then sift up from index = new count.
  - Response returns the pushed pair.
- POP:
  - When empty: rsp_err=1, rsp_key/rsp_val = 0.
  - Otherwise: respond with the root. The last element A[count] moves to the root position, count--, then sift down from index 1.
  - Popping the last entry: no sift, go straight to IDLE.
- REPLACE:
  - When empty: rsp_err=1, heap unchanged.
  - Otherwise: respond with the old root, then sift the new pair down from index 1; count is unchanged.
- Op 3: rsp_err=1, no state change.
- States:
  - IDLE
  - UP_RD: read parent at idx>>1.
  - UP_CMP: if better(new, parent), write parent to idx, idx >>= 1, return to UP_RD; else write new to idx, go to IDLE. When idx reaches 1, write new there.
  - LAST_RD: POP only; read A[old count].
  - DN_RDL: read left child at 2·idx.
  - DN_RDR: read right child; a missing child counts as "never better".
  - DN_CMP: let c = the better child (left wins ties). If better(c, new) is false, or there is no child, write new to idx and go to IDLE. Otherwise write c to idx, idx = child index, return to DN_RDL.
- Root register: updated on every RAM write to index 1, so it always equals A[1].
- Reset: all state clears and the heap is empty. A reset in the middle of an operation discards the operation; no response is issued.

## Timing
- Output values after reset:
  - cmd_ready = 1 (FSM is in IDLE).
  - rsp_valid, rsp_err, rsp_key, rsp_val = 0.
  - count = 0, empty = 1, full = 0.
- rsp_valid rises at t+1 for every command accepted at cycle t, including errors. The response is driven from the cached root or the command itself, not from sift completion.
- cmd_ready goes low from t+1 until the FSM is back in IDLE.
- An error command, a push into an empty heap, or a pop of the last entry returns to IDLE at t+1.
- RAM read latency is 1 cycle, with one read port and one write port. A read and a write in the same cycle to the same address return the old data; the FSM never depends on that case.
- Latency per level:
  - Sift-up: 2 cycles. Worst-case PUSH busy time = 2·(W_A−1)+1.
  - Sift-down: 3 cycles, plus 1 cycle of LAST_RD for POP.
- count, empty and full update at t+1.
- No new command can be accepted while busy, so commands never overlap.

## Structure
- Package heap_pq_pkg holds:
  - The op encodings.
  - The FSM state enum.
  - A better() function parametrised by MODE_MIN.
- Sub-module heap_pq_ram: a simple dual-port synchronous RAM, 2^W_A × (W_KEY+W_VAL), with one read port and one write port.

## Test plan
- Reset, then PUSH keys 5, 3, 8, 1 (MODE_MIN=1), then POP ×4 → rsp_key 1, 3, 5, 8; count 4→0; empty=1 at the end.
- POP on an empty heap → rsp_valid at t+1 with rsp_err=1, key 0; count stays 0.
- W_A=3: push 7 items, then push one more → full=1, rsp_err=1; a following POP returns the minimum with rsp_err=0.
- REPLACE on heap {2,4,6} with key 9 → rsp_key 2; the next three POPs return 4, 6, 9.
- MODE_MIN=0, PUSH 10, 30, 20 with vals 0xA, 0xC, 0xB → POPs return (30,0xC), (20,0xB), (10,0xA).
- Assert RST while a sift-down is in progress → no rsp_valid, count=0, cmd_ready=1 on the cycle after reset deasserts.
- Random 1000-command soak against a reference model → every response matches; cmd_ready is never high outside IDLE.

Source files
------------

// File: rtl/heap_pq_pkg.sv
// heap_pq_pkg
//   Shared definitions for the heap priority queue:
//   - op_e     : command op encodings carried on cmd_op
//   - state_e  : controller FSM states
//   - better() : ordering predicate, selectable min/max via mode_min
package heap_pq_pkg;

  // Widest key the ordering helper accepts; narrower keys are zero-extended.
  localparam int MAX_KEY_W = 64;

  typedef enum logic [1:0] {
    OP_PUSH    = 2'd0,
    OP_POP     = 2'd1,
    OP_REPLACE = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP_RD   = 3'd1,
    S_UP_CMP  = 3'd2,
    S_LAST_RD = 3'd3,
    S_DN_RDL  = 3'd4,
    S_DN_RDR  = 3'd5,
    S_DN_CMP  = 3'd6
  } state_e;

  // Non-strict ordering: a may sit at or above b. "a strictly better than b"
  // is expressed as !better(b, a), which keeps tied items where they are.
  function automatic logic better(input logic                 mode_min,
                                  input logic [MAX_KEY_W-1:0] a,
                                  input logic [MAX_KEY_W-1:0] b);
    if (mode_min) return (a <= b);
    else          return (a >= b);
  endfunction

endpackage

// File: rtl/heap_pq_if.sv
// heap_pq_if
//   Command/response bundle of the heap priority queue.
//   master : producer/consumer side (drives cmd_*, observes rsp_* and status)
//   slave  : queue side
//   Signals: cmd_valid/cmd_ready/cmd_op/cmd_key/cmd_val,
//            rsp_valid/rsp_err/rsp_key/rsp_val, count/empty/full.
interface heap_pq_if #(
  parameter int W_KEY = 32,
  parameter int W_VAL = 32,
  parameter int W_A   = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [W_KEY-1:0] cmd_key;
  logic [W_VAL-1:0] cmd_val;
  logic             rsp_valid;
  logic             rsp_err;
  logic [W_KEY-1:0] rsp_key;
  logic [W_VAL-1:0] rsp_val;
  logic [W_A-1:0]   count;
  logic             empty;
  logic             full;

  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_val,
    input  cmd_ready, rsp_valid, rsp_err, rsp_key, rsp_val, count, empty, full
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_val,
    output cmd_ready, rsp_valid, rsp_err, rsp_key, rsp_val, count, empty, full
  );
endinterface

// File: rtl/heap_pq_ram.sv
// heap_pq_ram
//   Simple dual-port synchronous RAM, 2^W_A words of W_D bits.
//   clk     : clock
//   i_we    : write enable, i_waddr/i_wdata write port
//   i_raddr : read address, o_rdata valid one cycle later
//   A read and write to the same address in one cycle returns the old word.
module heap_pq_ram #(
  parameter int W_A = 6,
  parameter int W_D = 64
) (
  input  logic           clk,
  input  logic           i_we,
  input  logic [W_A-1:0] i_waddr,
  input  logic [W_D-1:0] i_wdata,
  input  logic [W_A-1:0] i_raddr,
  output logic [W_D-1:0] o_rdata
);
  // Word 0 is never addressed by the heap (1-based indexing).
  logic [W_D-1:0] r_mem [2**W_A];
  logic [W_D-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/heap_pq.sv
// heap_pq
//   Binary-heap priority queue of key/value pairs, heap levels in a
//   synchronous RAM, root cached in a register.
//   CLK : clock, RST : synchronous active-high reset
//   bus : heap_pq_if slave (cmd_* in, rsp_* / count / empty / full out)
//   Ops: PUSH (sift up), POP (last -> root, sift down), REPLACE (new -> root,
//   sift down); reserved op and full/empty misuse answer with rsp_err.
//   Every accepted command gets its response on the following cycle.
module heap_pq
  import heap_pq_pkg::*;
#(
  parameter int W_KEY    = 32,
  parameter int W_VAL    = 32,
  parameter int W_A      = 6,
  parameter bit MODE_MIN = 1'b1
) (
  input  logic     CLK,
  input  logic     RST,
  heap_pq_if.slave bus
);
  localparam int             W_D  = W_KEY + W_VAL;
  localparam logic [W_A-1:0] CAP  = '1;
  localparam logic [W_A-1:0] ONE  = W_A'(1);
  localparam logic [W_A-1:0] ZERO = '0;

  state_e           r_state;
  logic [W_A-1:0]   r_count;
  logic [W_A-1:0]   r_idx;
  logic [W_KEY-1:0] r_new_key, r_root_key, r_left_key, r_rsp_key;
  logic [W_VAL-1:0] r_new_val, r_root_val, r_left_val, r_rsp_val;
  logic             r_has_l, r_has_r, r_load_new;
  logic             r_rsp_valid, r_rsp_err;

  logic             w_we;
  logic [W_A-1:0]   w_waddr, w_raddr;
  logic [W_D-1:0]   w_wdata, w_rdata;
  logic [W_KEY-1:0] w_rd_key, w_c_key;
  logic [W_VAL-1:0] w_rd_val, w_c_val;
  logic             w_accept, w_empty, w_full;
  logic             w_up_move, w_pick_r, w_dn_move;
  logic [W_A:0]     w_idx_l, w_idx_r;
  op_e              w_op;

  heap_pq_ram #(.W_A(W_A), .W_D(W_D)) u_ram (
    .clk     (CLK),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_rd_key = w_rdata[W_D-1:W_VAL];
  assign w_rd_val = w_rdata[W_VAL-1:0];
  assign w_op     = op_e'(bus.cmd_op);
  assign w_empty  = (r_count == ZERO);
  assign w_full   = (r_count == CAP);
  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
  // Child indices carry one extra bit so "beyond the last slot" is detectable.
  assign w_idx_l  = {r_idx, 1'b0};
  assign w_idx_r  = {r_idx, 1'b1};

  // Moves only happen on strict wins so tied items stay where they are.
  assign w_up_move = !better(MODE_MIN, MAX_KEY_W'(w_rd_key), MAX_KEY_W'(r_new_key));
  assign w_pick_r  = r_has_r && !better(MODE_MIN, MAX_KEY_W'(r_left_key), MAX_KEY_W'(w_rd_key));
  assign w_c_key   = w_pick_r ? w_rd_key : r_left_key;
  assign w_c_val   = w_pick_r ? w_rd_val : r_left_val;
  assign w_dn_move = r_has_l && !better(MODE_MIN, MAX_KEY_W'(r_new_key), MAX_KEY_W'(w_c_key));

  // RAM port control
  always_comb begin
    w_we    = 1'b0;
    w_waddr = ZERO;
    w_wdata = '0;
    w_raddr = ZERO;
    case (r_state)
      S_IDLE: begin
        // First entry goes straight into the root slot.
        if (w_accept && (w_op == OP_PUSH) && w_empty) begin
          w_we    = 1'b1;
          w_waddr = ONE;
          w_wdata = {bus.cmd_key, bus.cmd_val};
        end
      end
      S_UP_RD: begin
        if (r_idx == ONE) begin
          w_we    = 1'b1;
          w_waddr = ONE;
          w_wdata = {r_new_key, r_new_val};
        end else begin
          w_raddr = r_idx >> 1;
        end
      end
      S_UP_CMP: begin
        w_we    = 1'b1;
        w_waddr = r_idx;
        w_wdata = w_up_move ? w_rdata : {r_new_key, r_new_val};
      end
      S_LAST_RD: w_raddr = r_idx;
      S_DN_RDL:  w_raddr = w_idx_l[W_A-1:0];
      S_DN_RDR:  w_raddr = w_idx_r[W_A-1:0];
      S_DN_CMP: begin
        w_we    = 1'b1;
        w_waddr = r_idx;
        w_wdata = w_dn_move ? {w_c_key, w_c_val} : {r_new_key, r_new_val};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_count     <= ZERO;
      r_idx       <= ZERO;
      r_new_key   <= '0;
      r_new_val   <= '0;
      r_root_key  <= '0;
      r_root_val  <= '0;
      r_left_key  <= '0;
      r_left_val  <= '0;
      r_has_l     <= 1'b0;
      r_has_r     <= 1'b0;
      r_load_new  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_key   <= '0;
      r_rsp_val   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      // Mirror every root-slot write so r_root always equals A[1].
      if (w_we && (w_waddr == ONE)) begin
        r_root_key <= w_wdata[W_D-1:W_VAL];
        r_root_val <= w_wdata[W_VAL-1:0];
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            case (w_op)
              OP_PUSH: begin
                r_rsp_key <= bus.cmd_key;
                r_rsp_val <= bus.cmd_val;
                if (w_full) begin
                  r_rsp_err <= 1'b1;
                end else begin
                  r_count   <= r_count + ONE;
                  r_idx     <= r_count + ONE;
                  r_new_key <= bus.cmd_key;
                  r_new_val <= bus.cmd_val;
                  r_state   <= w_empty ? S_IDLE : S_UP_RD;
                end
              end
              OP_POP: begin
                if (w_empty) begin
                  r_rsp_err <= 1'b1;
                  r_rsp_key <= '0;
                  r_rsp_val <= '0;
                end else begin
                  r_rsp_key <= r_root_key;
                  r_rsp_val <= r_root_val;
                  r_count   <= r_count - ONE;
                  // r_idx holds the old count so LAST_RD fetches the tail entry.
                  r_idx     <= r_count;
                  if (r_count != ONE) r_state <= S_LAST_RD;
                end
              end
              OP_REPLACE: begin
                if (w_empty) begin
                  r_rsp_err <= 1'b1;
                  r_rsp_key <= '0;
                  r_rsp_val <= '0;
                end else begin
                  r_rsp_key  <= r_root_key;
                  r_rsp_val  <= r_root_val;
                  r_new_key  <= bus.cmd_key;
                  r_new_val  <= bus.cmd_val;
                  r_idx      <= ONE;
                  r_load_new <= 1'b0;
                  r_state    <= S_DN_RDL;
                end
              end
              default: begin
                r_rsp_err <= 1'b1;
                r_rsp_key <= '0;
                r_rsp_val <= '0;
              end
            endcase
          end
        end
        S_UP_RD: r_state <= (r_idx == ONE) ? S_IDLE : S_UP_CMP;
        S_UP_CMP: begin
          if (w_up_move) begin
            r_idx   <= r_idx >> 1;
            r_state <= S_UP_RD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LAST_RD: begin
          r_idx      <= ONE;
          r_load_new <= 1'b1;
          r_state    <= S_DN_RDL;
        end
        S_DN_RDL: begin
          // After a POP the sifting item is the tail entry read in LAST_RD.
          if (r_load_new) begin
            r_new_key  <= w_rd_key;
            r_new_val  <= w_rd_val;
            r_load_new <= 1'b0;
          end
          r_has_l <= (w_idx_l <= {1'b0, r_count});
          r_state <= S_DN_RDR;
        end
        S_DN_RDR: begin
          r_left_key <= w_rd_key;
          r_left_val <= w_rd_val;
          r_has_r    <= (w_idx_r <= {1'b0, r_count});
          r_state    <= S_DN_CMP;
        end
        S_DN_CMP: begin
          if (w_dn_move) begin
            r_idx   <= w_pick_r ? w_idx_r[W_A-1:0] : w_idx_l[W_A-1:0];
            r_state <= S_DN_RDL;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_key   = r_rsp_key;
  assign bus.rsp_val   = r_rsp_val;
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
endmodule
